// File: rtl/adder_test_pkg.sv
// Shared definitions for the adder test sequencer.
//   state_t     : sequencer FSM states
//   ERR_CNT_W   : width of the saturating mismatch counter
//   lfsr_taps() : Galois maximal-length feedback mask for a given width (2..31)
//   bit_reverse(): reverses the low 'width' bits of a 32-bit value
package adder_test_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int ERR_CNT_W  = 16;
    localparam int LFSR_MAX_W = 32;

    // Right-shifting Galois form: next = (s >> 1) ^ (s[0] ? taps : 0).
    function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int width);
        case (width)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_0009;
            5:       return 32'h0000_0012;
            6:       return 32'h0000_0021;
            7:       return 32'h0000_0041;
            8:       return 32'h0000_008E;
            9:       return 32'h0000_0108;
            10:      return 32'h0000_0204;
            11:      return 32'h0000_0402;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_4001;
            16:      return 32'h0000_8016;
            17:      return 32'h0001_0004;
            18:      return 32'h0002_0013;
            19:      return 32'h0004_0013;
            20:      return 32'h0008_0004;
            21:      return 32'h0010_0002;
            22:      return 32'h0020_0001;
            23:      return 32'h0040_0010;
            24:      return 32'h0080_000D;
            25:      return 32'h0100_0004;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0800_0004;
            29:      return 32'h1000_0002;
            30:      return 32'h2000_0029;
            default: return 32'h4000_0004;
        endcase
    endfunction

    function automatic logic [LFSR_MAX_W-1:0] bit_reverse(input logic [LFSR_MAX_W-1:0] v,
                                                          input int width);
        logic [LFSR_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < LFSR_MAX_W; i++) begin
            if (i < width) r[i] = v[width-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_opgen.sv
// Operand generator for the adder test sequencer.
//   i_clk, i_rst : clock, async active-high reset
//   load         : (re)initialise: LFSR <= seed (0 becomes 1), sweep index <= 0
//   advance      : step the active generator by one vector
//   mode         : 0 = LFSR / bit-reversed LFSR, 1 = carry-chain sweep k / -k
//   seed         : LFSR seed
//   a, b         : current operand pair (combinational from generator state)
module adder_opgen
    import adder_test_pkg::*;
#(
    parameter int WIDTH = 13
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             load,
    input  logic             advance,
    input  logic             mode,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b
);

    localparam logic [LFSR_MAX_W-1:0] TAPS_FULL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0]      TAPS      = TAPS_FULL[WIDTH-1:0];

    logic [WIDTH-1:0]      lfsr;
    logic [WIDTH-1:0]      lfsr_next;
    logic [WIDTH-1:0]      k;
    logic [WIDTH-1:0]      k_neg;
    logic [LFSR_MAX_W-1:0] rev_full;
    logic                  rev_unused;

    assign lfsr_next  = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    assign k_neg      = ~k + WIDTH'(1);
    assign rev_full   = bit_reverse(LFSR_MAX_W'(lfsr), WIDTH);
    assign rev_unused = ^rev_full[LFSR_MAX_W-1:WIDTH];

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        a = '0;
        b = '0;
        if (mode) begin
            a = k;
            b = k_neg;
        end else begin
            a = lfsr;
            b = rev_full[WIDTH-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lfsr <= '0;
            k    <= '0;
        end else if (load) begin
            lfsr <= (seed == '0) ? WIDTH'(1) : seed;
            k    <= '0;
        end else if (advance) begin
            if (mode) k <= k + WIDTH'(1);
            else      lfsr <= lfsr_next;
        end
    end

endmodule

// File: rtl/adder_test_sequencer.sv
// Self-checking stimulus/response stage around an adder under test.
//   i_clk, i_rst   : clock, async active-high reset
//   i_start        : one-cycle pulse, starts a run from IDLE or DONE
//   i_mode         : 0 = LFSR operands, 1 = carry-chain sweep
//   i_seed         : LFSR seed (0 behaves as 1)
//   o_add1, o_add2 : registered operands to the adder under test
//   i_dut_result   : adder sum including carry-out
//   o_busy         : high in RUN and DRAIN
//   o_done, o_pass : run finished / finished with zero mismatches
//   o_err_count    : saturating mismatch count
//   o_fail_*       : operands and result of the first mismatch
module adder_test_sequencer
    import adder_test_pkg::*;
#(
    parameter int WIDTH       = 13,
    parameter int NUM_VECTORS = 1024,
    parameter int DUT_LATENCY = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_mode,
    input  logic [WIDTH-1:0]     i_seed,
    output logic [WIDTH-1:0]     o_add1,
    output logic [WIDTH-1:0]     o_add2,
    input  logic [WIDTH:0]       i_dut_result,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass,
    output logic [ERR_CNT_W-1:0] o_err_count,
    output logic [WIDTH-1:0]     o_fail_add1,
    output logic [WIDTH-1:0]     o_fail_add2,
    output logic [WIDTH:0]       o_fail_result
);

    // Stage 0 holds the vector currently on o_add*; the tail lines up with
    // the DUT result DUT_LATENCY cycles later.
    localparam int                 DEPTH      = DUT_LATENCY + 1;
    localparam int                 DRAIN_W    = $clog2(DEPTH + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DUT_LATENCY);
    localparam logic [15:0]        LAST_VEC   = 16'(NUM_VECTORS - 1);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   sum;
    } vec_t;

    state_t               state;
    logic [15:0]          issue_cnt;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 mode_q;
    logic                 start_ok;
    logic [WIDTH-1:0]     gen_a;
    logic [WIDTH-1:0]     gen_b;
    logic [DEPTH-1:0]     pipe_valid;
    vec_t                 pipe_data [DEPTH];
    vec_t                 tail;
    logic                 mismatch;
    logic [ERR_CNT_W-1:0] err_inc;

    assign start_ok = i_start && (state == IDLE || state == DONE);
    assign tail     = pipe_data[DEPTH-1];
    assign mismatch = pipe_valid[DEPTH-1] && (i_dut_result != tail.sum);
    assign err_inc  = (o_err_count == '1) ? o_err_count : o_err_count + 1'b1;

    adder_opgen #(.WIDTH(WIDTH)) u_opgen (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .load    (start_ok),
        .advance (state == RUN),
        .mode    (mode_q),
        .seed    (i_seed),
        .a       (gen_a),
        .b       (gen_b)
    );

    // NOTE: the alignment payload is not reset; only the valid bits are, and
    // nothing reads the payload without a valid bit set.
    always_ff @(posedge i_clk) begin
        pipe_data[0] <= '{a: gen_a, b: gen_b, sum: {1'b0, gen_a} + {1'b0, gen_b}};
        for (int i = 1; i < DEPTH; i++) pipe_data[i] <= pipe_data[i-1];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            issue_cnt     <= '0;
            drain_cnt     <= '0;
            mode_q        <= 1'b0;
            pipe_valid    <= '0;
            o_add1        <= '0;
            o_add2        <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_pass        <= 1'b0;
            o_err_count   <= '0;
            o_fail_add1   <= '0;
            o_fail_add2   <= '0;
            o_fail_result <= '0;
        end else begin
            pipe_valid[0] <= (state == RUN);
            for (int i = 1; i < DEPTH; i++) pipe_valid[i] <= pipe_valid[i-1];

            if (mismatch) begin
                o_err_count <= err_inc;
                if (o_err_count == '0) begin
                    o_fail_add1   <= tail.a;
                    o_fail_add2   <= tail.b;
                    o_fail_result <= i_dut_result;
                end
            end

            case (state)
                IDLE, DONE: begin
                    // Pipeline is empty here, so clearing cannot race a compare.
                    if (i_start) begin
                        state         <= RUN;
                        issue_cnt     <= '0;
                        mode_q        <= i_mode;
                        o_busy        <= 1'b1;
                        o_done        <= 1'b0;
                        o_pass        <= 1'b0;
                        o_err_count   <= '0;
                        o_fail_add1   <= '0;
                        o_fail_add2   <= '0;
                        o_fail_result <= '0;
                    end
                end
                RUN: begin
                    o_add1    <= gen_a;
                    o_add2    <= gen_b;
                    issue_cnt <= issue_cnt + 16'd1;
                    if (issue_cnt == LAST_VEC) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        // The last in-flight compare lands on this same edge.
                        state  <= DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        o_pass <= (o_err_count == '0) && !mismatch;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_test_sequencer.sv
// Self-checking bench: four sequencer instances around bench-side adders.
//   u_a : 1024 vectors, combinational adder with optional operand-keyed fault
//   u_d : 8 vectors, combinational adder with optional carry-out stuck at 0
//   u_b : 32 vectors, DUT_LATENCY=2 against a 2-stage registered adder
//   u_c : 32 vectors, DUT_LATENCY=1 against the same kind of 2-stage adder
module tb_adder_test_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] rev13(input logic [12:0] v);
        logic [12:0] r;
        for (int i = 0; i < 13; i++) r[i] = v[12-i];
        return r;
    endfunction

    // ---------------- instance A ----------------
    logic a_start = 0, a_mode = 0, a_busy, a_done, a_pass, a_flip_en = 0;
    logic [12:0] a_seed = 0, a_add1, a_add2, a_fa1, a_fa2;
    logic [13:0] a_res, a_fres, a_flip_mask = 0;
    logic [3:0]  a_flip_nib = 0;
    logic [15:0] a_err;

    assign a_res = ({1'b0, a_add1} + {1'b0, a_add2}) ^
                   ((a_flip_en && a_add1[3:0] == a_flip_nib) ? a_flip_mask : 14'd0);

    adder_test_sequencer #(.WIDTH(13), .NUM_VECTORS(1024), .DUT_LATENCY(0)) u_a (
        .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_mode(a_mode), .i_seed(a_seed),
        .o_add1(a_add1), .o_add2(a_add2), .i_dut_result(a_res), .o_busy(a_busy),
        .o_done(a_done), .o_pass(a_pass), .o_err_count(a_err), .o_fail_add1(a_fa1),
        .o_fail_add2(a_fa2), .o_fail_result(a_fres));

    // ---------------- instance D ----------------
    logic d_start = 0, d_mode = 0, d_busy, d_done, d_pass, d_stuck = 0;
    logic [12:0] d_seed = 0, d_add1, d_add2, d_fa1, d_fa2;
    logic [13:0] d_res, d_fres;
    logic [15:0] d_err;
    logic [12:0] d_av [8];
    logic [12:0] d_bv [8];

    assign d_res = ({1'b0, d_add1} + {1'b0, d_add2}) & (d_stuck ? 14'h1FFF : 14'h3FFF);

    adder_test_sequencer #(.WIDTH(13), .NUM_VECTORS(8), .DUT_LATENCY(0)) u_d (
        .i_clk(clk), .i_rst(rst), .i_start(d_start), .i_mode(d_mode), .i_seed(d_seed),
        .o_add1(d_add1), .o_add2(d_add2), .i_dut_result(d_res), .o_busy(d_busy),
        .o_done(d_done), .o_pass(d_pass), .o_err_count(d_err), .o_fail_add1(d_fa1),
        .o_fail_add2(d_fa2), .o_fail_result(d_fres));

    // ---------------- instances B and C ----------------
    logic bc_start = 0;
    logic [12:0] bc_seed = 0;
    logic b_busy, b_done, b_pass, c_busy, c_done, c_pass;
    logic [12:0] b_add1, b_add2, b_fa1, b_fa2, c_add1, c_add2, c_fa1, c_fa2;
    logic [13:0] b_r1, b_r2, c_r1, c_r2, b_fres, c_fres;
    logic [15:0] b_err, c_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            b_r1 <= 0; b_r2 <= 0; c_r1 <= 0; c_r2 <= 0;
        end else begin
            b_r1 <= {1'b0, b_add1} + {1'b0, b_add2};
            b_r2 <= b_r1;
            c_r1 <= {1'b0, c_add1} + {1'b0, c_add2};
            c_r2 <= c_r1;
        end
    end

    adder_test_sequencer #(.WIDTH(13), .NUM_VECTORS(32), .DUT_LATENCY(2)) u_b (
        .i_clk(clk), .i_rst(rst), .i_start(bc_start), .i_mode(1'b0), .i_seed(bc_seed),
        .o_add1(b_add1), .o_add2(b_add2), .i_dut_result(b_r2), .o_busy(b_busy),
        .o_done(b_done), .o_pass(b_pass), .o_err_count(b_err), .o_fail_add1(b_fa1),
        .o_fail_add2(b_fa2), .o_fail_result(b_fres));

    adder_test_sequencer #(.WIDTH(13), .NUM_VECTORS(32), .DUT_LATENCY(1)) u_c (
        .i_clk(clk), .i_rst(rst), .i_start(bc_start), .i_mode(1'b0), .i_seed(bc_seed),
        .o_add1(c_add1), .o_add2(c_add2), .i_dut_result(c_r2), .o_busy(c_busy),
        .o_done(c_done), .o_pass(c_pass), .o_err_count(c_err), .o_fail_add1(c_fa1),
        .o_fail_add2(c_fa2), .o_fail_result(c_fres));

    // Full 1024-vector mode-0 run on A; reference derived from observed operands.
    task automatic run_a(input logic [12:0] seed, input bit flip_en, input string tag);
        logic [13:0] sum, dut, fres;
        logic [12:0] fa1, fa2;
        logic [12:0] first;
        bit   [8191:0] seen;
        int exp_err, rel_bad, dup, cyc;
        exp_err = 0; rel_bad = 0; dup = 0; cyc = 0; seen = '0;
        fa1 = 0; fa2 = 0; fres = 0; first = 0;
        a_flip_en = flip_en; a_seed = seed; a_mode = 0;
        @(negedge clk) a_start = 1;
        @(negedge clk) a_start = 0;
        check({tag, " busy"}, 32'(a_busy), 1);
        check({tag, " err cleared"}, 32'(a_err), 0);
        for (int i = 0; i < 1024; i++) begin
            @(posedge clk); #1;
            if (i == 0) first = a_add1;
            if (a_add2 !== rev13(a_add1) || a_add1 == 0) rel_bad++;
            if (seen[a_add1]) dup++;
            seen[a_add1] = 1'b1;
            sum = {1'b0, a_add1} + {1'b0, a_add2};
            dut = (flip_en && a_add1[3:0] == a_flip_nib) ? sum ^ a_flip_mask : sum;
            if (dut != sum) begin
                if (exp_err == 0) begin fa1 = a_add1; fa2 = a_add2; fres = dut; end
                exp_err++;
            end
        end
        while (!a_done && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check({tag, " first operand"}, 32'(first), (seed == 0) ? 1 : 32'(seed));
        check({tag, " bitrev relation"}, rel_bad, 0);
        check({tag, " distinct lfsr"}, dup, 0);
        check({tag, " done latency"}, cyc, 1);
        check({tag, " err count"}, 32'(a_err), 32'(exp_err));
        check({tag, " pass"}, 32'(a_pass), 32'(exp_err == 0));
        check({tag, " fail add1"}, 32'(a_fa1), 32'(fa1));
        check({tag, " fail add2"}, 32'(a_fa2), 32'(fa2));
        check({tag, " fail result"}, 32'(a_fres), 32'(fres));
    endtask

    // 8-vector run on D; optionally pokes i_start mid-run to show it is ignored.
    task automatic run_d(input bit mode, input logic [12:0] seed, input bit stuck,
                         input bit poke, input string tag);
        logic [13:0] sum, dut, fres;
        logic [12:0] fa1, fa2;
        int exp_err, cyc;
        exp_err = 0; cyc = 0; fa1 = 0; fa2 = 0; fres = 0;
        d_mode = mode; d_seed = seed; d_stuck = stuck;
        @(negedge clk) d_start = 1;
        @(negedge clk) d_start = 0;
        check({tag, " busy"}, 32'(d_busy), 1);
        check({tag, " cleared"}, {d_err, 13'(d_fa1), 1'b0, d_done, d_pass}, 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            d_start = 0;
            d_av[i] = d_add1;
            d_bv[i] = d_add2;
            if (poke && i == 3) d_start = 1;
        end
        d_start = 0;
        while (!d_done && cyc < 50) begin @(posedge clk); #1; cyc++; end
        for (int i = 0; i < 8; i++) begin
            sum = {1'b0, d_av[i]} + {1'b0, d_bv[i]};
            dut = stuck ? {1'b0, sum[12:0]} : sum;
            if (dut != sum) begin
                if (exp_err == 0) begin fa1 = d_av[i]; fa2 = d_bv[i]; fres = dut; end
                exp_err++;
            end
        end
        check({tag, " done latency"}, cyc, 1);
        check({tag, " err count"}, 32'(d_err), 32'(exp_err));
        check({tag, " pass"}, 32'(d_pass), 32'(exp_err == 0));
        check({tag, " fail add1"}, 32'(d_fa1), 32'(fa1));
        check({tag, " fail add2"}, 32'(d_fa2), 32'(fa2));
        check({tag, " fail result"}, 32'(d_fres), 32'(fres));
    endtask

    initial begin
        logic [12:0] s1 [8];
        int bad, cyc, c_cyc;

        // Reset state.
        #7;
        check("reset A outputs", {a_add1, a_add2, a_busy, a_done, a_pass}, 0);
        check("reset A counters", {a_err, a_fa1}, 0);
        check("reset D outputs", {d_add1, d_fres, d_busy, d_done}, 0);
        @(negedge clk) rst = 0;

        // Plan 1: ideal adder, LFSR mode, seed 1ACE.
        run_a(13'h1ACE, 1'b0, "A seed1ACE");

        // Plan 2: carry-chain sweep, ideal adder.
        run_d(1'b1, 13'h0, 1'b0, 1'b0, "D sweep");
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (d_av[i] != 13'(i) || d_bv[i] != 13'(8192 - i)) bad++;
            if (({1'b0, d_av[i]} + {1'b0, d_bv[i]}) != ((i == 0) ? 14'h0 : 14'h2000)) bad++;
        end
        check("D sweep operands", bad, 0);

        // Plan 3: carry-out stuck at 0 (expected 7 errors, first at k=1).
        run_d(1'b1, 13'h0, 1'b1, 1'b0, "D stuck13");
        check("D stuck13 literal count", 32'(d_err), 7);
        check("D stuck13 literal first", {d_fa1, d_fa2, d_fres}, {13'd1, 13'h1FFF, 14'd0});

        // Plan 6: restart from DONE clears state; i_start during RUN ignored.
        run_d(1'b1, 13'h0, 1'b0, 1'b1, "D restart+poke");
        bad = 0;
        for (int i = 0; i < 8; i++) if (d_av[i] != 13'(i)) bad++;
        check("D poke ignored", bad, 0);

        // Seed 0 behaves like seed 1.
        run_d(1'b0, 13'h1, 1'b0, 1'b0, "D seed1");
        for (int i = 0; i < 8; i++) s1[i] = d_av[i];
        run_d(1'b0, 13'h0, 1'b0, 1'b0, "D seed0");
        bad = 0;
        for (int i = 0; i < 8; i++) if (d_av[i] != s1[i] || d_bv[i] != rev13(s1[i])) bad++;
        check("D seed0 == seed1", bad, 0);

        // Plan 4: 2-stage adder, latency 2 (aligned) vs latency 1 (misaligned).
        bc_seed = 13'($urandom_range(1, 8191));
        @(negedge clk) bc_start = 1;
        @(negedge clk) bc_start = 0;
        cyc = 0; c_cyc = 0;
        while (!b_done && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (c_done && c_cyc == 0) c_cyc = cyc;
        end
        check("B done latency", cyc, 35);
        check("C done latency", c_cyc, 34);
        check("B err", 32'(b_err), 0);
        check("B pass", 32'(b_pass), 1);
        check("C err nonzero", 32'(c_err != 0), 1);
        check("C pass", 32'(c_pass), 0);

        // Plan 5: reset in the middle of RUN, with errors already counted.
        a_flip_en = 1; a_flip_nib = 0; a_flip_mask = 14'h0001; a_seed = 13'h0777;
        @(negedge clk) a_start = 1;
        @(negedge clk) a_start = 0;
        for (int i = 0; i <= 300; i++) begin @(posedge clk); #1; end
        check("A pre-reset busy", 32'(a_busy), 1);
        rst = 1; #1;
        check("A mid-run reset outputs", {a_add1, a_add2, a_busy, a_done, a_pass}, 0);
        check("A mid-run reset counters", {a_err, a_fa2}, 0);
        check("A mid-run reset fail result", 32'(a_fres), 0);
        @(negedge clk) rst = 0;

        // Fresh full runs with randomized seed and fault pattern.
        for (int r = 0; r < 2; r++) begin
            a_flip_nib  = 4'($urandom);
            a_flip_mask = 14'($urandom_range(1, 16383));
            run_a(13'($urandom), 1'b1, $sformatf("A rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
